// File: rtl/uart_rx_fifo_pkg.sv
// Shared sizing constants for the UART receive FIFO slice.
//   DATA_W : width of one stored word (one UART byte)
//   ADDR_W : storage address width; depth = 2**ADDR_W
//   CNT_W  : width of the occupancy count, 0..2**ADDR_W
package uart_rx_fifo_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_rx_fifo_if.sv
// Push/pop/status bundle between the UART receiver side, the consumer and the FIFO.
//   master : drives push, wdata, pop, clr_err; observes head data and status
//   slave  : the FIFO itself
interface uart_rx_fifo_if;
    import uart_rx_fifo_pkg::*;

    logic              push;
    logic [DATA_W-1:0] wdata;
    logic              pop;
    logic              clr_err;
    logic [DATA_W-1:0] rdata;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic              udf;

    modport master (
        output push, wdata, pop, clr_err,
        input  rdata, empty, full, count, ovf, udf
    );

    modport slave (
        input  push, wdata, pop, clr_err,
        output rdata, empty, full, count, ovf, udf
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_rx_fifo_fifo_regfile.sv
// Storage array for the UART receive FIFO.
//   clk   : clock
//   we    : write enable, stores wdata at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : word at raddr
// Contents are deliberately not reset; the pointer logic decides what is valid.
module fifo_regfile
    import uart_rx_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port
    assign rdata = mem[raddr];

endmodule : fifo_regfile

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO directly behind the UART receiver.
//   clk : system clock
//   rst : synchronous active-high reset; discards all stored entries
//   bus : slave side of uart_rx_fifo_if
//         push/wdata  - receiver done pulse and received byte
//         pop         - consumer acknowledge of the head byte
//         clr_err     - clears the sticky ovf/udf flags
//         rdata       - head byte (0 while empty)
//         empty/full/count - occupancy status
//         ovf/udf     - sticky overflow / underflow flags
// Status outputs depend only on registers; push/pop never reach an output combinationally.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              ovf_q;
    logic              udf_q;

    logic              empty_c;
    logic              full_c;
    logic              wr_acc_c;
    logic              rd_acc_c;
    logic              ovf_set_c;
    logic              udf_set_c;
    logic [DATA_W-1:0] head_c;

    // Occupancy from the extra pointer MSB: equal pointers = empty, MSB-only difference = full
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // A pop frees the head slot in the same edge, so a full FIFO still accepts push+pop
    assign wr_acc_c  = bus.push & (~full_c | bus.pop);
    assign rd_acc_c  = bus.pop & ~empty_c;
    assign ovf_set_c = bus.push & full_c & ~bus.pop;
    assign udf_set_c = bus.pop & empty_c;

    fifo_regfile u_regfile (
        .clk   (clk),
        .we    (wr_acc_c),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (bus.wdata),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (head_c)
    );

    // Pointer and sticky-flag registers; a new error event wins over clr_err
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            ovf_q <= ovf_set_c | (ovf_q & ~bus.clr_err);
            udf_q <= udf_set_c | (udf_q & ~bus.clr_err);
        end
    end

    assign bus.rdata = empty_c ? '0 : head_c;
    assign bus.empty = empty_c;
    assign bus.full  = full_c;
    assign bus.count = CNT_W'(wr_ptr - rd_ptr);
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [7:0] model_q [$];
    logic [7:0] exp_b;
    logic [7:0] last_b;

    uart_rx_fifo_if bus ();

    uart_rx_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs settle before the edge, outputs sampled 1 time unit after
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
        bus.wdata   = 8'h00;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // 1. Reset state
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full",  32'(bus.full),  32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ovf",   32'(bus.ovf),   32'd0);
        chk("rst_udf",   32'(bus.udf),   32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'h00);

        // 2. Three pushes then three pops
        bus.push = 1'b1;
        bus.wdata = 8'h41; cyc();
        chk("t2_cnt1",   32'(bus.count), 32'd1);
        chk("t2_head41", 32'(bus.rdata), 32'h41);
        chk("t2_nempty", 32'(bus.empty), 32'd0);
        bus.wdata = 8'h42; cyc();
        chk("t2_cnt2",   32'(bus.count), 32'd2);
        bus.wdata = 8'h43; cyc();
        chk("t2_cnt3",   32'(bus.count), 32'd3);
        idle();
        bus.pop = 1'b1;
        chk("t2_rd41",   32'(bus.rdata), 32'h41); cyc();
        chk("t2_cnt2b",  32'(bus.count), 32'd2);
        chk("t2_rd42",   32'(bus.rdata), 32'h42); cyc();
        chk("t2_cnt1b",  32'(bus.count), 32'd1);
        chk("t2_rd43",   32'(bus.rdata), 32'h43); cyc();
        chk("t2_cnt0",   32'(bus.count), 32'd0);
        chk("t2_empty",  32'(bus.empty), 32'd1);
        chk("t2_udf",    32'(bus.udf),   32'd0);
        idle();

        // 3. Fill to 16, overflow attempt, drain
        bus.push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wdata = 8'(i);
            cyc();
        end
        chk("t3_full",  32'(bus.full),  32'd1);
        chk("t3_cnt16", 32'(bus.count), 32'd16);
        chk("t3_ovf0",  32'(bus.ovf),   32'd0);
        bus.wdata = 8'hAA; cyc();
        chk("t3_ovf1",   32'(bus.ovf),   32'd1);
        chk("t3_cnt16b", 32'(bus.count), 32'd16);
        chk("t3_head0",  32'(bus.rdata), 32'h00);
        idle();
        bus.pop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_rd%0d", i), 32'(bus.rdata), 32'(i));
            cyc();
        end
        idle();
        chk("t3_empty",  32'(bus.empty), 32'd1);
        chk("t3_ovfkeep", 32'(bus.ovf),  32'd1);
        bus.clr_err = 1'b1; cyc();
        idle();
        chk("t3_ovfclr", 32'(bus.ovf),   32'd0);

        // 4. Full-FIFO push+pop streaming across two pointer wraps
        model_q.delete();
        bus.push = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wdata = 8'h10 + 8'(i);
            model_q.push_back(bus.wdata);
            cyc();
        end
        chk("t4_full", 32'(bus.full), 32'd1);
        bus.pop = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.wdata = (i == 0) ? 8'h55 : (8'h80 + 8'(i));
            exp_b = model_q.pop_front();
            model_q.push_back(bus.wdata);
            chk($sformatf("t4_head%0d", i), 32'(bus.rdata), 32'(exp_b));
            cyc();
            chk($sformatf("t4_cnt%0d", i), 32'(bus.count), 32'd16);
            chk($sformatf("t4_ovf%0d", i), 32'(bus.ovf),   32'd0);
        end
        bus.push = 1'b0;
        last_b = 8'h00;
        for (int i = 0; i < 16; i++) begin
            exp_b = model_q.pop_front();
            last_b = bus.rdata;
            chk($sformatf("t4_drain%0d", i), 32'(bus.rdata), 32'(exp_b));
            cyc();
        end
        idle();
        chk("t4_last",  32'(last_b),    32'hA7);
        chk("t4_empty", 32'(bus.empty), 32'd1);

        // 5. Underflow, push+pop while empty, clear, set-wins-over-clear
        bus.pop = 1'b1; cyc();
        idle();
        chk("t5_udf1",   32'(bus.udf),   32'd1);
        chk("t5_cnt0",   32'(bus.count), 32'd0);
        bus.push = 1'b1; bus.pop = 1'b1; bus.wdata = 8'h7E; cyc();
        idle();
        chk("t5_udfkeep", 32'(bus.udf),  32'd1);
        chk("t5_cnt1",   32'(bus.count), 32'd1);
        chk("t5_rd7e",   32'(bus.rdata), 32'h7E);
        bus.clr_err = 1'b1; cyc();
        idle();
        chk("t5_udfclr", 32'(bus.udf),   32'd0);
        chk("t5_ovfclr", 32'(bus.ovf),   32'd0);
        bus.pop = 1'b1; cyc();
        chk("t5_udfnone", 32'(bus.udf),  32'd0);
        bus.clr_err = 1'b1; cyc();
        idle();
        chk("t5_setwins", 32'(bus.udf),  32'd1);
        bus.clr_err = 1'b1; cyc();
        idle();

        // 6. Reset mid-stream together with a push
        bus.push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.wdata = 8'hC0 + 8'(i);
            cyc();
        end
        chk("t6_cnt5", 32'(bus.count), 32'd5);
        bus.wdata = 8'hEE;
        rst = 1'b1; cyc();
        idle();
        rst = 1'b0;
        chk("t6_empty", 32'(bus.empty), 32'd1);
        chk("t6_cnt0",  32'(bus.count), 32'd0);
        chk("t6_rdata", 32'(bus.rdata), 32'h00);
        cyc();
        chk("t6_stillempty", 32'(bus.empty), 32'd1);
        chk("t6_full",  32'(bus.full), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fifo
